fibo_job_scheduler: RTL

Round-robin scheduler that shares one fibonacci_calculator among NREQ requesters. It accepts {requester, index} jobs and sequences the calculator through clear, start and wait-for-done. It returns the 28-bit result, tagged with the requester ID, over a valid/ready response channel. Out-of-range indices and calculator hangs are reported as errors and never stall the block.

---
 rtl/fibo_job_scheduler.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/fibo_job_scheduler.sv
// Round-robin scheduler sharing one Fibonacci calculator among NREQ requesters; accept->CLR->START->WAIT->RESP.
// Out-of-range indices and calculator hangs become error responses; RESP holds until rsp_ready.
module fibo_job_scheduler #(
  parameter int NREQ    = 4,
  parameter int MAX_N   = 35,
  parameter int TIMEOUT = 64
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [5*NREQ-1:0] req_index,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [2:0]        rsp_id,
  output logic [27:0]       rsp_data,
  output logic              rsp_err,
  output logic              busy,
  output logic [4:0]        calc_input_s,
  output logic              calc_reset,
  output logic              calc_begin,
  input  logic [27:0]       calc_out,
  input  logic              calc_done
);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {IDLE, CLR, START, WAIT, RESP} state_t;

  state_t      r_state;
  logic [2:0]  r_rr_ptr;
  logic [2:0]  r_job_id;
  logic [4:0]  r_job_idx;
  logic [27:0] r_rsp_data;
  logic        r_rsp_err;
  logic        r_rsp_valid;
  logic        r_busy;
  logic        r_clr;
  logic        r_calc_begin;
  logic [CW-1:0] r_cnt;

  logic        w_any;
  logic [2:0]  w_winner;
  logic [4:0]  w_win_idx;

  // Scan downward so the last hit is the first set bit at or after rr_ptr.
  always_comb begin
    w_any    = 1'b0;
    w_winner = r_rr_ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(r_rr_ptr) + k) % NREQ]) begin
        w_any    = 1'b1;
        w_winner = 3'((int'(r_rr_ptr) + k) % NREQ);
      end
    end
  end

  assign w_win_idx = req_index[int'(w_winner) * 5 +: 5];

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = (r_state == IDLE) && w_any && (w_winner == 3'(i));
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state      <= IDLE;
      r_rr_ptr     <= '0;
      r_job_id     <= '0;
      r_job_idx    <= '0;
      r_rsp_data   <= '0;
      r_rsp_err    <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_clr        <= 1'b0;
      r_calc_begin <= 1'b0;
      r_cnt        <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_job_id  <= w_winner;
            r_job_idx <= w_win_idx;
            r_busy    <= 1'b1;
            if (int'(w_win_idx) > MAX_N) begin
              r_rsp_data  <= '0;
              r_rsp_err   <= 1'b1;
              r_rsp_valid <= 1'b1;
              r_state     <= RESP;
            end else begin
              r_clr   <= 1'b1;
              r_state <= CLR;
            end
          end
        end
        CLR: begin
          r_clr        <= 1'b0;
          r_calc_begin <= 1'b1;
          r_state      <= START;
        end
        START: begin
          r_calc_begin <= 1'b0;
          r_cnt        <= '0;
          r_state      <= WAIT;
        end
        WAIT: begin
          // done has priority over the timeout in the same cycle
          if (calc_done) begin
            r_rsp_data  <= calc_out;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end else if (r_cnt == CW'(TIMEOUT - 1)) begin
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_rr_ptr    <= 3'((int'(r_job_id) + 1) % NREQ);
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rsp_valid    = r_rsp_valid;
  assign rsp_id       = r_job_id;
  assign rsp_data     = r_rsp_data;
  assign rsp_err      = r_rsp_err;
  assign busy         = r_busy;
  assign calc_input_s = r_job_idx;
  assign calc_begin   = r_calc_begin;
  assign calc_reset   = ~RST_N | r_clr;

endmodule
